// File: rtl/ander_stim_seq.sv
// Stimulus/self-check stage for the ander gate: steps (a,b) through 00,01,10,11 with a dwell per vector.
// Optional ANDER_STIM_LOOP_EN: with start held at the last check, wrap and keep accumulating errors.
module ander_stim_seq #(
   parameter int DWELL = 20,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             result,
   output logic             a,
   output logic             b,
   output logic [1:0]       vec_idx,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_cnt
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRIVE = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam int              DW_W       = (DWELL > 2) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [1:0]      state;
   logic [DW_W-1:0] dwell;
   logic            mismatch;

   // a/b come straight from the vec_idx flops, so they always switch together on one edge.
   assign a        = vec_idx[1];
   assign b        = vec_idx[0];
   assign mismatch = (result != (a & b));

   // NOTE: every register here uses non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         dwell   <= '0;
         vec_idx <= 2'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err_cnt <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state   <= DRIVE;
                  vec_idx <= 2'd0;
                  err_cnt <= '0;
                  dwell   <= '0;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            DRIVE: begin
               // Also retires the one-cycle done pulse produced by a looped pass.
               done  <= 1'b0;
               dwell <= dwell + DW_W'(1);
               if (dwell == DWELL_LAST) state <= CHECK;
            end
            CHECK: begin
               if (mismatch && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_W'(1);
`ifdef ANDER_STIM_LOOP_EN
               if ((vec_idx == 2'd3) && start) begin
                  vec_idx <= 2'd0;
                  dwell   <= '0;
                  done    <= 1'b1;
                  state   <= DRIVE;
               end else
`endif
               if (vec_idx == 2'd3) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  vec_idx <= vec_idx + 2'd1;
                  dwell   <= '0;
                  state   <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ander_stim_seq.sv
// Self-checking bench for ander_stim_seq: a cycle-count reference model compared every cycle,
// plus literal checks of latency, error counts, saturation and restart behaviour.
module tb_ander_stim_seq;

   localparam int DWELL  = 20;
   localparam int CNT_W  = 2;
   localparam int PERIOD = DWELL + 1;
   localparam int MAXC   = (1 << CNT_W) - 1;
`ifdef ANDER_STIM_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             result;
   logic             a, b, busy, done;
   logic [1:0]       vec_idx;
   logic [CNT_W-1:0] err_cnt;

   int   mode = 0;        // 0 real ander, 1 stuck-0, 2 stuck-1, 3 random, 4 inverted
   logic rnd_bit = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   ander_stim_seq #(.DWELL(DWELL), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .result(result),
      .a(a), .b(b), .vec_idx(vec_idx), .busy(busy), .done(done), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      result = a & b;
      case (mode)
         1: result = 1'b0;
         2: result = 1'b1;
         3: result = rnd_bit;
         4: result = ~(a & b);
         default: result = a & b;
      endcase
   end

   initial forever begin
      @(posedge clk);
      #3 rnd_bit = 1'($urandom_range(0, 1));
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a sequence is just a cycle count k from the start edge;
   // vector = k / (DWELL+1), the result is judged on the last cycle of each period.
   logic s_start = 1'b0, s_result = 1'b0;
   bit   m_run = 0, m_done = 0;
   int   m_k = 0, m_vec = 0, m_err = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run = 0; m_done = 0; m_k = 0; m_vec = 0; m_err = 0;
      end else if (m_run) begin
         m_done = 0;
         if (m_k % PERIOD == DWELL) begin
            if (s_result != (m_vec == 3)) m_err = (m_err < MAXC) ? m_err + 1 : MAXC;
            if (m_vec == 3) begin
               m_done = 1;
               if (LOOP && s_start) begin m_k = 0; m_vec = 0; end
               else m_run = 0;
            end else begin
               m_k++;
               m_vec = m_k / PERIOD;
            end
         end else m_k++;
      end else if (s_start) begin
         m_run = 1; m_k = 0; m_vec = 0; m_err = 0; m_done = 0;
      end
   end

   always @(negedge clk) begin
      check("vec_idx", 32'(vec_idx), 32'(m_vec));
      check("a", 32'(a), 32'((m_vec >> 1) & 1));
      check("b", 32'(b), 32'(m_vec & 1));
      check("busy", 32'(busy), 32'(m_run));
      check("done", 32'(done), 32'(m_done));
      check("err_cnt", 32'(err_cnt), 32'(m_err));
      s_start  = start;
      s_result = result;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 300) begin
         tick();
         lat++;
      end
      check("done_reached", 32'(done), 32'd1);
   endtask

   task automatic run_pulse(output int lat);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(lat);
   endtask

   int lat;
   int pulses[3];
   int np;

   initial begin
      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_vec", 32'(vec_idx), 32'd0);
      check("rst_err", 32'(err_cnt), 32'd0);
      rst = 1'b0;
      repeat (2) tick();

      // Clean pass with a real AND gate
      mode = 0;
      run_pulse(lat);
      check("clean_latency", 32'(lat), 32'd84);
      check("clean_err", 32'(err_cnt), 32'd0);
      check("clean_busy", 32'(busy), 32'd0);
      check("clean_ab", 32'({a, b}), 32'd3);

      mode = 1;
      run_pulse(lat);
      check("stuck0_err", 32'(err_cnt), 32'd1);
      mode = 2;
      run_pulse(lat);
      check("stuck1_err", 32'(err_cnt), 32'd3);
      run_pulse(lat);
      check("stuck1_rerun_err", 32'(err_cnt), 32'd3);
      mode = 4;
      run_pulse(lat);
      check("inverted_saturates", 32'(err_cnt), 32'(MAXC));

      // Reset in the middle of a run clears everything immediately
      mode = 2;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (30) tick();
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_err", 32'(err_cnt), 32'd0);
      check("midrst_vec", 32'(vec_idx), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      mode = 0;
      run_pulse(lat);
      check("post_rst_latency", 32'(lat), 32'd84);
      check("post_rst_err", 32'(err_cnt), 32'd0);

`ifndef ANDER_STIM_LOOP_EN
      // start held high: ignored while busy, restarts straight from DONE
      start = 1'b1;
      tick();
      wait_done(lat);
      check("held_latency", 32'(lat), 32'd84);
      tick();
      check("held_restart_busy", 32'(busy), 32'd1);
      check("held_restart_done", 32'(done), 32'd0);
      start = 1'b0;
      wait_done(lat);
      check("held_second_latency", 32'(lat), 32'd84);
`else
      // Looping: three passes with stuck-1, done pulses 84 cycles apart
      mode = 2;
      np = 0;
      start = 1'b1;
      tick();
      for (int i = 1; i <= 400; i++) begin
         tick();
         if (done && np < 3) begin
            pulses[np] = i;
            np++;
            if (np == 2) start = 1'b0;
         end
         if (!busy) break;
      end
      check("loop_pulses", 32'(np), 32'd3);
      check("loop_p0", 32'(pulses[0]), 32'd84);
      check("loop_p1", 32'(pulses[1]), 32'd168);
      check("loop_p2", 32'(pulses[2]), 32'd252);
      check("loop_sat_err", 32'(err_cnt), 32'(MAXC));
      check("loop_end_busy", 32'(busy), 32'd0);
`endif

      // Randomised runs: result mode, start noise and occasional resets
      for (int r = 0; r < 12; r++) begin
         int  i;
         bit  noise, do_rst;
         int  rst_at;
         mode   = int'($urandom_range(0, 4));
         noise  = 1'($urandom_range(0, 1));
         do_rst = ($urandom_range(0, 3) == 0);
         rst_at = int'($urandom_range(1, 80));
         start = 1'b1;
         tick();
         start = 1'b0;
         for (i = 1; i < 600; i++) begin
            tick();
            if (do_rst && i == rst_at) begin
               rst = 1'b1;
               tick();
               rst = 1'b0;
               break;
            end
            if (!busy) break;
            start = (noise && i < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         start = 1'b0;
         check("rand_run_bounded", 32'(i < 600), 32'd1);
         repeat (3) tick();
      end

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
